// File: rtl/debug_hart_ctrl.sv
// -----------------------------------------------------------------------------
// debug_hart_ctrl
//
// Takes Debug Module commands and sequences them onto the core debug interface.
// Commands are halt, resume, GPR read/write and CSR read/write. Exactly one
// command is in flight at a time, and every accepted command produces exactly
// one response. Register strobes are only issued while the core is halted.
//
// Optional feature:
//   DEBUG_CSR_ACCESS_EN - when defined, regnos 0x0000-0x0FFF reach the CSR port.
//                         When undefined, CSR regnos are rejected with err=1,
//                         the csr_* outputs stay 0 and csr_rdata_i is ignored.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid_i/req_ready_o    command handshake (ready only in IDLE)
//   req_op_i                   0=read reg, 1=write reg, 2=halt, 3=resume
//   req_regno_i                0x0000-0x0FFF CSR, 0x1000-0x101F GPR x0-x31
//   req_wdata_i                write data
//   rsp_valid_o/rsp_ready_i    response handshake
//   rsp_err_o, rsp_rdata_o     status, and read data (0 unless a good read)
//   halted_i                   core is in debug halt
//   haltreq_o, resumereq_o     halt/resume request levels
//   gpr_wr_o/index/wdata/rdata GPR access port
//   csr_wr_o/index/wdata/rdata CSR access port
// -----------------------------------------------------------------------------
module debug_hart_ctrl #(
  parameter int XLEN         = 64,
  parameter int HALT_TIMEOUT = 1024,
  parameter int TMO_BITS     = 11
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [1:0]      req_op_i,
  input  logic [15:0]     req_regno_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic            rsp_err_o,
  output logic [XLEN-1:0] rsp_rdata_o,
  input  logic            halted_i,
  output logic            haltreq_o,
  output logic            resumereq_o,
  output logic            gpr_wr_o,
  output logic [4:0]      gpr_index_o,
  output logic [XLEN-1:0] gpr_wdata_o,
  input  logic [XLEN-1:0] gpr_rdata_i,
  output logic            csr_wr_o,
  output logic [11:0]     csr_index_o,
  output logic [XLEN-1:0] csr_wdata_o,
  input  logic [XLEN-1:0] csr_rdata_i
);

  typedef enum logic [2:0] {
    IDLE,
    HALT_WAIT,
    RESUME_WAIT,
    ACCESS,
    READ,
    RESP
  } state_t;

  localparam logic [1:0] OP_READ   = 2'd0;
  localparam logic [1:0] OP_WRITE  = 2'd1;
  localparam logic [1:0] OP_HALT   = 2'd2;
  localparam logic [1:0] OP_RESUME = 2'd3;

  localparam logic [TMO_BITS-1:0] TMO_LAST = TMO_BITS'(HALT_TIMEOUT - 1);

  // CSR path enable and the read-data source for the CSR side.
  logic [XLEN-1:0] csr_rdata_sel;
`ifdef DEBUG_CSR_ACCESS_EN
  localparam bit CSR_EN = 1'b1;
  assign csr_rdata_sel = csr_rdata_i;
`else
  localparam bit CSR_EN = 1'b0;
  assign csr_rdata_sel = '0;
  logic unused_csr_rdata;
  assign unused_csr_rdata = ^csr_rdata_i;
`endif

  state_t              state;
  logic [TMO_BITS-1:0] tmo_cnt;
  logic                op_write_q;  // latched: command is a write
  logic                tgt_gpr_q;   // latched: target is the GPR port

  // Request decode, evaluated in the acceptance cycle.
  logic is_gpr;
  logic is_csr;
  logic access_legal;

  assign is_gpr       = (req_regno_i[15:5] == 11'h080);   // 0x1000-0x101F
  assign is_csr       = (req_regno_i[15:12] == 4'h0);     // 0x0000-0x0FFF
  assign access_legal = halted_i & (is_gpr | (CSR_EN & is_csr));

  assign req_ready_o = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      op_write_q  <= 1'b0;
      tgt_gpr_q   <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= '0;
      haltreq_o   <= 1'b0;
      resumereq_o <= 1'b0;
      gpr_wr_o    <= 1'b0;
      gpr_index_o <= '0;
      gpr_wdata_o <= '0;
      csr_wr_o    <= 1'b0;
      csr_index_o <= '0;
      csr_wdata_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            op_write_q <= (req_op_i == OP_WRITE);
            tgt_gpr_q  <= is_gpr;
            tmo_cnt    <= '0;
            case (req_op_i)
              OP_HALT: begin
                if (halted_i) begin
                  state       <= RESP;
                  rsp_valid_o <= 1'b1;
                  rsp_err_o   <= 1'b0;
                  rsp_rdata_o <= '0;
                end else begin
                  state     <= HALT_WAIT;
                  haltreq_o <= 1'b1;
                end
              end
              OP_RESUME: begin
                if (!halted_i) begin
                  state       <= RESP;
                  rsp_valid_o <= 1'b1;
                  rsp_err_o   <= 1'b0;
                  rsp_rdata_o <= '0;
                end else begin
                  state       <= RESUME_WAIT;
                  resumereq_o <= 1'b1;
                end
              end
              default: begin  // OP_READ / OP_WRITE
                if (!access_legal) begin
                  // Rejected without touching the register ports.
                  state       <= RESP;
                  rsp_valid_o <= 1'b1;
                  rsp_err_o   <= 1'b1;
                  rsp_rdata_o <= '0;
                end else begin
                  state <= ACCESS;
                  if (is_gpr) begin
                    gpr_index_o <= req_regno_i[4:0];
                    gpr_wdata_o <= req_wdata_i;
                    gpr_wr_o    <= (req_op_i == OP_WRITE);
                  end else if (CSR_EN) begin
                    csr_index_o <= req_regno_i[11:0];
                    csr_wdata_o <= req_wdata_i;
                    csr_wr_o    <= (req_op_i == OP_WRITE);
                  end
                end
              end
            endcase
          end
        end

        HALT_WAIT: begin
          if (halted_i || tmo_cnt == TMO_LAST) begin
            state       <= RESP;
            haltreq_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= ~halted_i;
            rsp_rdata_o <= '0;
          end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        RESUME_WAIT: begin
          if (!halted_i || tmo_cnt == TMO_LAST) begin
            state       <= RESP;
            resumereq_o <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= halted_i;
            rsp_rdata_o <= '0;
          end else if (tmo_cnt != '1) begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        ACCESS: begin
          // Write strobes last exactly this one cycle.
          gpr_wr_o <= 1'b0;
          csr_wr_o <= 1'b0;
          if (op_write_q) begin
            state       <= RESP;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
          end else begin
            state <= READ;
          end
        end

        READ: begin
          // Index has been stable for a full cycle; read data is valid now.
          state       <= RESP;
          rsp_valid_o <= 1'b1;
          rsp_err_o   <= 1'b0;
          rsp_rdata_o <= tgt_gpr_q ? gpr_rdata_i : csr_rdata_sel;
        end

        RESP: begin
          if (rsp_ready_i) begin
            state       <= IDLE;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_hart_ctrl.sv
module tb_debug_hart_ctrl;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid_i;
  logic            req_ready_o;
  logic [1:0]      req_op_i;
  logic [15:0]     req_regno_i;
  logic [XLEN-1:0] req_wdata_i;
  logic            rsp_valid_o;
  logic            rsp_ready_i;
  logic            rsp_err_o;
  logic [XLEN-1:0] rsp_rdata_o;
  logic            halted_i;
  logic            haltreq_o;
  logic            resumereq_o;
  logic            gpr_wr_o;
  logic [4:0]      gpr_index_o;
  logic [XLEN-1:0] gpr_wdata_o;
  logic [XLEN-1:0] gpr_rdata_i;
  logic            csr_wr_o;
  logic [11:0]     csr_index_o;
  logic [XLEN-1:0] csr_wdata_o;
  logic [XLEN-1:0] csr_rdata_i;

  debug_hart_ctrl #(
    .XLEN(XLEN), .HALT_TIMEOUT(16), .TMO_BITS(5)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_regno_i(req_regno_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_err_o(rsp_err_o), .rsp_rdata_o(rsp_rdata_o),
    .halted_i(halted_i), .haltreq_o(haltreq_o), .resumereq_o(resumereq_o),
    .gpr_wr_o(gpr_wr_o), .gpr_index_o(gpr_index_o),
    .gpr_wdata_o(gpr_wdata_o), .gpr_rdata_i(gpr_rdata_i),
    .csr_wr_o(csr_wr_o), .csr_index_o(csr_index_o),
    .csr_wdata_o(csr_wdata_o), .csr_rdata_i(csr_rdata_i)
  );

  always #5 clk = ~clk;

  // Core model: GPR read data encodes the presented index; CSR data fixed.
  assign gpr_rdata_i = 64'hC0DE_0000_0000_0000 | 64'(gpr_index_o);
  assign csr_rdata_i = 64'h1800;

`ifdef DEBUG_CSR_ACCESS_EN
  localparam bit CSR_ON = 1'b1;
`else
  localparam bit CSR_ON = 1'b0;
`endif

  // Per-cycle activity counters, sampled just before each active edge.
  int haltreq_cyc = 0;
  int resumereq_cyc = 0;
  int gpr_wr_cyc = 0;
  int csr_wr_cyc = 0;
  always @(posedge clk) begin
    if (haltreq_o)   haltreq_cyc++;
    if (resumereq_o) resumereq_cyc++;
    if (gpr_wr_o)    gpr_wr_cyc++;
    if (csr_wr_o)    csr_wr_cyc++;
  end

  int checks = 0;
  int errors = 0;
  logic [64:0] exp_q[$];   // {err, rdata}

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [15:0] regno,
                      input logic [63:0] wd, input logic e_err, input logic [63:0] e_rdata);
    int n = 0;
    while (!req_ready_o && n < 50) begin @(negedge clk); n++; end
    check("req_ready", req_ready_o, 1);
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_regno_i = regno;
    req_wdata_i = wd;
    exp_q.push_back({e_err, e_rdata});
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask

  task automatic get_rsp(input string tag, input int hold);
    int n = 0;
    logic [64:0] e;
    logic        err0;
    logic [63:0] d0;
    while (!rsp_valid_o && n < 60) begin @(negedge clk); n++; end
    check({tag, "_rsp_valid"}, rsp_valid_o, 1);
    if (rsp_valid_o) begin
      if (exp_q.size() == 0) begin
        check({tag, "_unexpected_rsp"}, 1, 0);
      end else begin
        e = exp_q.pop_front();
        check({tag, "_err"}, rsp_err_o, e[64]);
        check({tag, "_rdata"}, rsp_rdata_o, e[63:0]);
      end
      err0 = rsp_err_o;
      d0   = rsp_rdata_o;
      if (hold > 0) begin
        // Offer a competing request while the response is back-pressured.
        req_valid_i = 1'b1;
        req_op_i    = 2'd2;
        for (int i = 0; i < hold; i++) begin
          @(negedge clk);
          check({tag, "_hold_valid"}, rsp_valid_o, 1);
          check({tag, "_hold_err"}, rsp_err_o, err0);
          check({tag, "_hold_rdata"}, rsp_rdata_o, d0);
          check({tag, "_hold_req_ready"}, req_ready_o, 0);
        end
      end
      req_valid_i = 1'b0;
      rsp_ready_i = 1'b1;
      @(negedge clk);
      rsp_ready_i = 1'b0;
      check({tag, "_rsp_drop"}, rsp_valid_o, 0);
      check({tag, "_idle_ready"}, req_ready_o, 1);
      $display("txn %s err=%0d rdata=0x%0h", tag, err0, d0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0, r0, g0, c0;
    rst_n = 1'b0; req_valid_i = 1'b0; req_op_i = '0; req_regno_i = '0;
    req_wdata_i = '0; rsp_ready_i = 1'b0; halted_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready_o, 1);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_haltreq", haltreq_o, 0);
    check("rst_resumereq", resumereq_o, 0);
    check("rst_gpr_wr", gpr_wr_o, 0);
    check("rst_gpr_index", gpr_index_o, 0);
    check("rst_csr_wr", csr_wr_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Halt; core answers 5 cycles after the request.
    h0 = haltreq_cyc;
    send(2'd2, 16'h0, 64'h0, 1'b0, 64'h0);
    check("halt_req_high", haltreq_o, 1);
    repeat (5) @(negedge clk);
    halted_i = 1'b1;
    get_rsp("halt_delayed", 0);
    check("halt_req_cycles", 64'(haltreq_cyc - h0), 6);
    check("halt_req_low", haltreq_o, 0);

    // Resume; core leaves halt 3 cycles later.
    r0 = resumereq_cyc;
    send(2'd3, 16'h0, 64'h0, 1'b0, 64'h0);
    repeat (3) @(negedge clk);
    halted_i = 1'b0;
    get_rsp("resume_delayed", 0);
    check("resume_req_cycles", 64'(resumereq_cyc - r0), 4);

    // Halt that never completes: timeout after 16 cycles.
    h0 = haltreq_cyc;
    send(2'd2, 16'h0, 64'h0, 1'b1, 64'h0);
    get_rsp("halt_timeout", 0);
    check("halt_tmo_cycles", 64'(haltreq_cyc - h0), 16);
    check("halt_tmo_req_low", haltreq_o, 0);

    // Register access while running is rejected.
    g0 = gpr_wr_cyc;
    send(2'd0, 16'h1001, 64'h0, 1'b1, 64'h0);
    get_rsp("read_running", 0);
    check("read_running_index", gpr_index_o, 0);
    check("read_running_strobe", 64'(gpr_wr_cyc - g0), 0);

    // Already halted: immediate success, no request.
    halted_i = 1'b1;
    h0 = haltreq_cyc;
    send(2'd2, 16'h0, 64'h0, 1'b0, 64'h0);
    get_rsp("halt_immediate", 0);
    check("halt_imm_cycles", 64'(haltreq_cyc - h0), 0);

    // GPR write.
    g0 = gpr_wr_cyc;
    send(2'd1, 16'h100A, 64'hDEADBEEF, 1'b0, 64'h0);
    get_rsp("gpr_write", 0);
    check("gpr_write_pulses", 64'(gpr_wr_cyc - g0), 1);
    check("gpr_write_index", gpr_index_o, 10);
    check("gpr_write_wdata", gpr_wdata_o, 64'hDEADBEEF);

    // GPR read.
    g0 = gpr_wr_cyc;
    send(2'd0, 16'h1005, 64'h0, 1'b0, 64'hC0DE_0000_0000_0005);
    get_rsp("gpr_read", 0);
    check("gpr_read_no_strobe", 64'(gpr_wr_cyc - g0), 0);

    // CSR read and write, behaviour depends on the CSR option.
    c0 = csr_wr_cyc;
    send(2'd0, 16'h0300, 64'h0, !CSR_ON, CSR_ON ? 64'h1800 : 64'h0);
    get_rsp("csr_read", 0);
    check("csr_read_no_strobe", 64'(csr_wr_cyc - c0), 0);
    c0 = csr_wr_cyc;
    send(2'd1, 16'h0341, 64'h55, !CSR_ON, 64'h0);
    get_rsp("csr_write", 0);
    check("csr_write_pulses", 64'(csr_wr_cyc - c0), CSR_ON ? 1 : 0);
    check("csr_write_index", csr_index_o, CSR_ON ? 64'h341 : 64'h0);
    check("csr_write_wdata", csr_wdata_o, CSR_ON ? 64'h55 : 64'h0);

    // Out-of-range regno.
    g0 = gpr_wr_cyc;
    send(2'd1, 16'h2000, 64'h1, 1'b1, 64'h0);
    get_rsp("bad_regno", 0);
    check("bad_regno_strobe", 64'(gpr_wr_cyc - g0), 0);

    // Write to x0 is forwarded.
    g0 = gpr_wr_cyc;
    send(2'd1, 16'h1000, 64'h77, 1'b0, 64'h0);
    get_rsp("gpr_write_x0", 0);
    check("x0_pulses", 64'(gpr_wr_cyc - g0), 1);
    check("x0_index", gpr_index_o, 0);

    // Response back-pressure with a competing request.
    send(2'd0, 16'h1003, 64'h0, 1'b0, 64'hC0DE_0000_0000_0003);
    get_rsp("backpressure", 10);

    // halted_i falls during ACCESS: the write still completes.
    g0 = gpr_wr_cyc;
    send(2'd1, 16'h1007, 64'h99, 1'b0, 64'h0);
    halted_i = 1'b0;
    get_rsp("write_unhalt", 0);
    check("unhalt_pulses", 64'(gpr_wr_cyc - g0), 1);

    // Reset while waiting for halt aborts without a response.
    send(2'd2, 16'h0, 64'h0, 1'b0, 64'h0);
    void'(exp_q.pop_back());
    repeat (3) @(negedge clk);
    check("abort_haltreq_before", haltreq_o, 1);
    rst_n = 1'b0;
    #1;
    check("abort_haltreq", haltreq_o, 0);
    check("abort_rsp_valid", rsp_valid_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_req_ready", req_ready_o, 1);
    check("abort_no_rsp", rsp_valid_o, 0);
    check("abort_haltreq_after", haltreq_o, 0);

    // Normal operation after the abort.
    halted_i = 1'b1;
    send(2'd2, 16'h0, 64'h0, 1'b0, 64'h0);
    get_rsp("halt_after_reset", 0);
    check("queue_empty", 64'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debug_hart_ctrl.md
Name: debug_hart_ctrl

Overview:
- Sequences debug Debug Module (DM) commands onto the core's pipdebug_interface: halt, resume, GPR read/write and CSR read/write.
- Sits between the DM request side and the core. It owns the haltreq/resumereq handshakes and guarantees that register strobes only reach the core while the core is halted.
- Exactly one command is in flight at a time. Every accepted command returns exactly one response.

Parameters:
- XLEN, 64, register data width.
- HALT_TIMEOUT, 1024, cycles to wait for halted_i to change before flagging an error; minimum 2.
- TMO_BITS, 11, timeout counter width; must satisfy 2^TMO_BITS > HALT_TIMEOUT.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  1  command valid
- req_ready_o  out  1  command accepted when valid&ready
- req_op_i  in  2  0=read reg, 1=write reg, 2=halt, 3=resume
- req_regno_i  in  16  abstract regno: 0x0000-0x0FFF CSR, 0x1000-0x101F GPR x0-x31
- req_wdata_i  in  XLEN  write data
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_err_o  out  1  command failed
- rsp_rdata_o  out  XLEN  read data; 0 for non-reads and for errors
- halted_i  in  1  core is in debug halt
- haltreq_o  out  1  halt request level
- resumereq_o  out  1  resume request level
- gpr_wr_o  out  1  GPR write strobe
- gpr_index_o  out  5  GPR index
- gpr_wdata_o  out  XLEN  GPR write data
- gpr_rdata_i  in  XLEN  GPR read data
- csr_wr_o  out  1  CSR write strobe
- csr_index_o  out  12  CSR address
- csr_wdata_o  out  XLEN  CSR write data
- csr_rdata_i  in  XLEN  CSR read data

Behaviour:
- Reset: state=IDLE; every output is 0 except req_ready_o=1. Reset asserted mid-command aborts the command with no response and drops haltreq_o/resumereq_o immediately.
- req_ready_o = (state==IDLE). Command fields are latched when the command is accepted.
- States: IDLE, HALT_WAIT, RESUME_WAIT, ACCESS, READ, RESP.
- IDLE, op=halt:
  - If halted_i=1, go to RESP with err=0.
  - Otherwise go to HALT_WAIT: haltreq_o=1 and the timeout counter clears.
- HALT_WAIT:
  - halted_i=1: haltreq_o drops next edge, go to RESP, err=0.
  - Counter reaches HALT_TIMEOUT-1: go to RESP, err=1, haltreq_o drops.
- op=resume: mirror of halt. Immediate success if halted_i=0; otherwise RESUME_WAIT holds resumereq_o=1 until halted_i=0 or timeout.
- op=read/write, admissibility:
  - Command is illegal if halted_i=0 at acceptance, or if the regno falls outside both the GPR and CSR ranges.
  - An illegal command goes straight to RESP with err=1 and issues no strobe.
- op=read/write, legal command:
  - Goes to ACCESS. Index and wdata are driven from the latched fields.
  - Write: gpr_wr_o or csr_wr_o pulses for exactly this one cycle, then RESP.
  - Read: index is held through ACCESS and READ. rdata is sampled at the end of READ (read latency 1 cycle after the index is presented), then RESP.
- Index/wdata outputs hold their last value between commands; strobes never repeat.
- A write to GPR x0 is forwarded as a normal write; the core ignores it. Response err=0.
- RESP: rsp_valid_o=1 with err/rdata stable until rsp_ready_i. On the handshake edge the block returns to IDLE. The next command can be accepted no earlier than the following cycle.
- If halted_i falls during ACCESS/READ, the access completes normally (no abort).
- The timeout counter saturates and never wraps.

Optional Feature:
- Macro DEBUG_CSR_ACCESS_EN.
- Defined: CSR regnos are accessed as described above.
- Undefined:
  - CSR regnos are treated as illegal and return err=1.
  - csr_wr_o is tied 0; csr_index_o and csr_wdata_o are tied 0; csr_rdata_i is unused.
  - GPR, halt and resume behaviour is unchanged.

Test Plan:
- Halt with halted_i=0, core raises halted_i 5 cycles after haltreq_o -> haltreq_o high for 5-6 cycles, then one response err=0; haltreq_o=0 afterwards.
- Halt with halted_i never rising, HALT_TIMEOUT=16 -> haltreq_o high exactly 16 cycles, response err=1.
- Halted core, write regno 0x100A data 0xDEADBEEF -> single gpr_wr_o pulse, gpr_index_o=10, gpr_wdata_o=0xDEADBEEF, response err=0.
- Halted core, read regno 0x0300 with csr_rdata_i=0x1800 -> response rdata=0x1800, err=0, csr_wr_o stays 0. With DEBUG_CSR_ACCESS_EN undefined -> err=1, rdata=0.
- Running core (halted_i=0), read 0x1001 -> err=1, no index change, no strobe. Regno 0x2000 while halted -> err=1.
- Hold rsp_ready_i=0 for 10 cycles while offering a new request -> response stable, req_ready_o=0. Assert rst_n=0 in HALT_WAIT -> haltreq_o, rsp_valid_o=0 at once, req_ready_o=1 after reset.
